// File: rtl/pipeline_barrier_pkg.sv
// Shared definitions for the inter-stage barriers: state encoding and default widths.
package core_defs;
   localparam int DATA_W_DEF      = 32;
   localparam int CTRL_W_DEF      = 8;
   localparam int STALL_CNT_W_DEF = 16;

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;
endpackage

// File: rtl/pipeline_barrier.sv
// Inter-stage barrier: valid/ready register slice with a one-entry skid, flush and stall counter.
// up_ready, dn_valid and dn_ctrl are all flops so no combinational path crosses stages.
module pipeline_barrier
   import core_defs::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CTRL_W      = CTRL_W_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   up_valid,
   output logic                   up_ready,
   input  logic [DATA_W-1:0]      up_data,
   input  logic [CTRL_W-1:0]      up_ctrl,
   output logic                   dn_valid,
   input  logic                   dn_ready,
   output logic [DATA_W-1:0]      dn_data,
   output logic [CTRL_W-1:0]      dn_ctrl,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   state_e            state;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              up_fire;
   logic              dn_fire;

   assign up_fire   = up_valid & up_ready;
   assign dn_fire   = dn_valid & dn_ready;
   assign occupancy = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_EMPTY;
         up_ready  <= 1'b1;
         dn_valid  <= 1'b0;
         dn_data   <= '0;
         dn_ctrl   <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
         stall_cnt <= '0;
      end else begin
         if (dn_valid && !dn_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);

         if (flush) begin
            // dn_data keeps its value; clearing ctrl is what makes the bubble harmless.
            state    <= ST_EMPTY;
            up_ready <= 1'b1;
            dn_valid <= 1'b0;
            dn_ctrl  <= '0;
         end else begin
            case (state)
               ST_EMPTY: begin
                  if (up_fire) begin
                     state    <= ST_ONE;
                     dn_valid <= 1'b1;
                     dn_data  <= up_data;
                     dn_ctrl  <= up_ctrl;
                  end
               end
               ST_ONE: begin
                  if (up_fire && dn_fire) begin
                     dn_data <= up_data;
                     dn_ctrl <= up_ctrl;
                  end else if (up_fire) begin
                     state     <= ST_FULL;
                     up_ready  <= 1'b0;
                     skid_data <= up_data;
                     skid_ctrl <= up_ctrl;
                  end else if (dn_fire) begin
                     state    <= ST_EMPTY;
                     dn_valid <= 1'b0;
                     dn_ctrl  <= '0;
                  end
               end
               ST_FULL: begin
                  if (dn_fire) begin
                     state    <= ST_ONE;
                     up_ready <= 1'b1;
                     dn_data  <= skid_data;
                     dn_ctrl  <= skid_ctrl;
                  end
               end
               default: begin
                  state    <= ST_EMPTY;
                  up_ready <= 1'b1;
                  dn_valid <= 1'b0;
                  dn_ctrl  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipeline_barrier.sv
// Directed and scoreboarded checks of pipeline_barrier; a second instance with a 2-bit stall counter covers saturation.
module tb_pipeline_barrier;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        up_valid;
   logic        up_ready, up_ready_s;
   logic [31:0] up_data;
   logic [7:0]  up_ctrl;
   logic        dn_valid, dn_valid_s;
   logic        dn_ready;
   logic [31:0] dn_data, dn_data_s;
   logic [7:0]  dn_ctrl, dn_ctrl_s;
   logic [1:0]  occupancy, occupancy_s;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_barrier #(.DATA_W(32), .CTRL_W(8), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ctrl(up_ctrl),
      .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_ctrl(dn_ctrl),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipeline_barrier #(.DATA_W(32), .CTRL_W(8), .STALL_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .up_valid(up_valid), .up_ready(up_ready_s), .up_data(up_data), .up_ctrl(up_ctrl),
      .dn_valid(dn_valid_s), .dn_ready(dn_ready), .dn_data(dn_data_s), .dn_ctrl(dn_ctrl_s),
      .occupancy(occupancy_s), .stall_cnt(stall_cnt_s)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] d, input logic [7:0] c);
      up_valid = 1'b1;
      up_data  = d;
      up_ctrl  = c;
   endtask

   initial begin
      logic [31:0] q_data[$];
      logic [7:0]  q_ctrl[$];
      logic [31:0] seq, cap_d;
      logic [7:0]  cap_c;
      logic        uf, df, ur;

      rst = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
      up_data = '0; up_ctrl = '0;
      cyc(); cyc();
      chk("rst_up_ready", up_ready, 1);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_dn_data", dn_data, 0);
      chk("rst_dn_ctrl", dn_ctrl, 0);
      chk("rst_stall", stall_cnt, 0);
      rst = 1'b1;
      cyc();

      // streaming: one cycle latency, occupancy stays 1
      dn_ready = 1'b1;
      offer(32'h10, 8'h01); cyc();
      chk("str0_data", dn_data, 32'h10);
      chk("str0_ctrl", dn_ctrl, 8'h01);
      offer(32'h14, 8'h02); cyc();
      chk("str1_data", dn_data, 32'h14);
      chk("str1_occ", occupancy, 1);
      offer(32'h18, 8'h03); cyc();
      chk("str2_data", dn_data, 32'h18);
      chk("str2_occ", occupancy, 1);
      chk("str2_up_ready", up_ready, 1);
      up_valid = 1'b0; cyc();
      chk("str_drain_valid", dn_valid, 0);
      chk("str_drain_ctrl", dn_ctrl, 0);
      chk("str_drain_hold", dn_data, 32'h18);
      chk("str_drain_occ", occupancy, 0);

      // skid: second entry lands in skid, ready drops, order preserved
      dn_ready = 1'b0;
      offer(32'h5, 8'h33); cyc();
      chk("skid_occ1", occupancy, 1);
      offer(32'hA, 8'h44); cyc();
      chk("skid_occ2", occupancy, 2);
      chk("skid_up_ready", up_ready, 0);
      chk("skid_main", dn_data, 32'h5);
      up_valid = 1'b0; dn_ready = 1'b1; cyc();
      chk("skid_second", dn_data, 32'hA);
      chk("skid_second_ctrl", dn_ctrl, 8'h44);
      chk("skid_ready_back", up_ready, 1);
      cyc();
      chk("skid_empty", occupancy, 0);

      // flush with two entries held and one offered
      dn_ready = 1'b0;
      offer(32'h100, 8'hFF); cyc();
      offer(32'h104, 8'hFF); cyc();
      chk("fl_pre_occ", occupancy, 2);
      offer(32'h108, 8'hFF); flush = 1'b1; cyc();
      flush = 1'b0; up_valid = 1'b0;
      chk("fl_dn_valid", dn_valid, 0);
      chk("fl_dn_ctrl", dn_ctrl, 0);
      chk("fl_occ", occupancy, 0);
      chk("fl_up_ready", up_ready, 1);
      cyc();
      chk("fl_absent", dn_valid, 0);
      // flush while empty and accepting: the offered entry is dropped
      offer(32'h200, 8'h11); flush = 1'b1; cyc();
      flush = 1'b0; up_valid = 1'b0;
      chk("fl_empty_valid", dn_valid, 0);
      chk("fl_empty_occ", occupancy, 0);

      // asynchronous reset mid-stream with occ=2
      offer(32'h300, 8'h77); cyc();
      offer(32'h304, 8'h78); cyc();
      up_valid = 1'b0;
      chk("ar_pre_occ", occupancy, 2);
      rst = 1'b0; #1;
      chk("ar_occ", occupancy, 0);
      chk("ar_dn_valid", dn_valid, 0);
      chk("ar_dn_data", dn_data, 0);
      chk("ar_dn_ctrl", dn_ctrl, 0);
      chk("ar_up_ready", up_ready, 1);
      chk("ar_stall", stall_cnt, 0);
      cyc();
      rst = 1'b1;
      cyc();
      chk("ar_release_ready", up_ready, 1);
      chk("ar_release_valid", dn_valid, 0);

      // stall counter and its saturation in the 2-bit instance
      offer(32'h55, 8'h09); cyc();
      up_valid = 1'b0;
      chk("st_start", stall_cnt, 0);
      repeat (5) cyc();
      chk("st_five", stall_cnt, 5);
      chk("st_sat_five", stall_cnt_s, 3);
      cyc();
      chk("st_six", stall_cnt, 6);
      chk("st_sat_six", stall_cnt_s, 3);
      dn_ready = 1'b1; cyc();
      chk("st_delivered", dn_valid, 0);
      chk("st_hold", stall_cnt, 6);
      flush = 1'b1; cyc(); flush = 1'b0;
      chk("st_flush_keeps", stall_cnt, 6);

      // random valid/ready against a FIFO scoreboard
      seq = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
         if (!up_valid && $urandom_range(0, 3) != 0) begin
            offer(seq, seq[7:0] ^ 8'hA5);
            seq++;
         end
         ur = up_ready;
         dn_ready = ($urandom_range(0, 2) != 0);
         #1;
         chk("rnd_ready_regd", up_ready, ur);
         if (!dn_valid) chk("rnd_bubble_ctrl", dn_ctrl, 0);
         uf = up_valid && up_ready;
         df = dn_valid && dn_ready;
         cap_d = dn_data; cap_c = dn_ctrl;
         cyc();
         if (df) begin
            if (q_data.size() == 0) chk("rnd_spurious", 1, 0);
            else begin
               chk("rnd_data", cap_d, q_data.pop_front());
               chk("rnd_ctrl", cap_c, q_ctrl.pop_front());
            end
         end
         if (uf) begin
            q_data.push_back(up_data);
            q_ctrl.push_back(up_ctrl);
            up_valid = 1'b0;
         end
         chk("rnd_occ", occupancy, q_data.size());
      end
      up_valid = 1'b0; dn_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         df = dn_valid; cap_d = dn_data;
         if (df && q_data.size() != 0) begin
            chk("drain_data", cap_d, q_data.pop_front());
            void'(q_ctrl.pop_front());
         end
         cyc();
      end
      chk("drain_left", q_data.size(), 0);
      chk("drain_valid", dn_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
